// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port (instruction fetch / data) arbiter in front of a
//             single-ported memory with a fixed number of wait states.
//             Data requests win over fetch requests. Each access runs
//             IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE (ack pulse)
//             -> IDLE.
//  Options  : `define ARB_STARVE_GUARD_EN to enable a 2-bit starvation
//             counter. After STARVE_MAX consecutive data wins made while
//             fetch was waiting, the next grant goes to fetch.
//  Ports    : clk, clrn (async active-low reset)
//             i_req/i_addr -> i_ack/i_rdata          fetch port
//             d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata  data port
//             m_en/m_we/m_addr/m_wdata <- m_rdata     memory side
//             stall_if, stall_mem, busy               status (combinational)
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int STARVE_MAX  = 3
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        busy
);

    localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_gnt_d;   // 1: current access belongs to the data port
    logic       r_we;      // latched write flag of the current access

    logic       w_force_fetch;
    logic       w_grant_d;
    logic       w_grant_i;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [1:0] C_STARVE_MAX = 2'(STARVE_MAX);

    logic [1:0] r_starve;

    assign w_force_fetch = (r_starve == C_STARVE_MAX);

    // Counts data wins taken while fetch was also waiting; any fetch grant
    // clears it. It only moves on an actual IDLE-state grant.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_starve <= 2'd0;
        end else if (r_state == S_IDLE) begin
            if (w_grant_i) begin
                r_starve <= 2'd0;
            end else if (w_grant_d && i_req) begin
                r_starve <= r_starve + 2'd1;
            end
        end
    end
`else
    logic w_unused_starve;

    assign w_force_fetch   = 1'b0;
    assign w_unused_starve = ^STARVE_MAX;
`endif

    // Data wins unless the starvation guard forces a pending fetch through.
    assign w_grant_d = d_req & ~(i_req & w_force_fetch);
    assign w_grant_i = i_req & ~w_grant_d;

    assign stall_if  = i_req & ~i_ack;
    assign stall_mem = d_req & ~d_ack;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_gnt_d <= 1'b0;
            r_we    <= 1'b0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= 32'd0;
            m_wdata <= 32'd0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= 32'd0;
            d_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    m_en  <= 1'b0;
                    m_we  <= 1'b0;
                    if (w_grant_d || w_grant_i) begin
                        r_gnt_d <= w_grant_d;
                        r_cnt   <= C_WAIT;
                        m_en    <= 1'b1;
                        r_state <= S_ACCESS;
                        if (w_grant_d) begin
                            r_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            // With zero wait states the first ACCESS cycle
                            // is already the strobe cycle.
                            m_we    <= d_we && (C_WAIT == 4'd0);
                        end else begin
                            r_we    <= 1'b0;
                            m_addr  <= i_addr;
                        end
                    end
                end

                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                        m_en    <= 1'b0;
                        m_we    <= 1'b0;
                        if (!r_we) begin
                            if (r_gnt_d) begin
                                d_rdata <= m_rdata;
                            end else begin
                                i_rdata <= m_rdata;
                            end
                        end
                        if (r_gnt_d) begin
                            d_ack <= 1'b1;
                        end else begin
                            i_ack <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        // Strobe is registered: raise it for the cycle in
                        // which the counter will read zero.
                        m_we  <= r_we && (r_cnt == 4'd1);
                    end
                end

                S_DONE: begin
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

    logic        clk  = 1'b0;
    logic        clrn = 1'b0;

    // Main instance (WAIT_CYCLES = 2)
    logic        i_req   = 1'b0;
    logic [31:0] i_addr  = 32'd0;
    logic        d_req   = 1'b0;
    logic        d_we    = 1'b0;
    logic [31:0] d_addr  = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [31:0] m_rdata = 32'd0;
    logic        i_ack, d_ack, m_en, m_we, stall_if, stall_mem, busy;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

    // Zero-wait-state instance
    logic        z_i_req   = 1'b0;
    logic [31:0] z_i_addr  = 32'd0;
    logic        z_d_req   = 1'b0;
    logic        z_d_we    = 1'b0;
    logic [31:0] z_d_addr  = 32'd0;
    logic [31:0] z_d_wdata = 32'd0;
    logic [31:0] z_m_rdata = 32'd0;
    logic        z_i_ack, z_d_ack, z_m_en, z_m_we, z_stall_if, z_stall_mem, z_busy;
    logic [31:0] z_i_rdata, z_d_rdata, z_m_addr, z_m_wdata;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    int we_cnt   = 0;
    int iack_cnt = 0;
    int dack_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        we_cnt   <= we_cnt + int'(m_we);
        iack_cnt <= iack_cnt + int'(i_ack);
        dack_cnt <= dack_cnt + int'(d_ack);
    end

    mem_arbiter #(.WAIT_CYCLES(2), .STARVE_MAX(3)) u_dut (
        .clk(clk), .clrn(clrn),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    mem_arbiter #(.WAIT_CYCLES(0), .STARVE_MAX(3)) u_dut0 (
        .clk(clk), .clrn(clrn),
        .i_req(z_i_req), .i_addr(z_i_addr), .i_ack(z_i_ack), .i_rdata(z_i_rdata),
        .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
        .d_ack(z_d_ack), .d_rdata(z_d_rdata),
        .m_en(z_m_en), .m_we(z_m_we), .m_addr(z_m_addr), .m_wdata(z_m_wdata),
        .m_rdata(z_m_rdata),
        .stall_if(z_stall_if), .stall_mem(z_stall_mem), .busy(z_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int          we0, ia0, da0;
        int          n_ev;
        logic [4:0]  ev;
        logic        stall_ok;

        // ---------------- reset state ----------------
        #3;
        check("rst_m_en",   32'(m_en),   32'd0);
        check("rst_acks",   32'({i_ack, d_ack, m_we}), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_m_addr", m_addr,      32'd0);
        check("rst_rdata",  i_rdata | d_rdata | m_wdata, 32'd0);
        tick();
        tick();
        clrn = 1'b1;
        tick();

        // ---------------- fetch only ----------------
        we0 = we_cnt;
        i_req = 1'b1; i_addr = 32'h40; m_rdata = 32'h8C010004;
        #1;
        check("fetch_stall_if_pre", 32'(stall_if), 32'd1);
        tick();                                   // sampling edge
        i_req = 1'b0;                             // drop: access must still finish
        check("fetch_busy",   32'(busy),   32'd1);
        check("fetch_m_en",   32'(m_en),   32'd1);
        check("fetch_m_addr", m_addr,      32'h40);
        tick();
        tick();
        check("fetch_ack_early", 32'(i_ack), 32'd0);
        tick();                                   // ack high before edge 4 after sample
        check("fetch_ack",    32'(i_ack),  32'd1);
        check("fetch_rdata",  i_rdata,     32'h8C010004);
        check("fetch_m_en_done", 32'(m_en), 32'd0);
        check("fetch_m_addr_hold", m_addr, 32'h40);
        tick();
        check("fetch_ack_pulse", 32'(i_ack), 32'd0);
        check("fetch_idle",   32'(busy),   32'd0);
        check("fetch_no_we",  32'(we_cnt - we0), 32'd0);

        // ---------------- store ----------------
        we0 = we_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
        tick();                                   // sampling edge
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h99; d_wdata = 32'h0;  // post-grant changes
        check("store_we_c2", 32'(m_we), 32'd0);
        tick();
        check("store_we_c1", 32'(m_we), 32'd0);
        tick();
        check("store_we_c0",  32'(m_we), 32'd1);
        check("store_m_addr", m_addr,    32'h10);
        check("store_m_wdata", m_wdata,  32'hDEADBEEF);
        tick();
        check("store_dack",   32'(d_ack), 32'd1);
        check("store_we_off", 32'(m_we),  32'd0);
        check("store_drdata", d_rdata,    32'd0);
        check("store_wdata_hold", m_wdata, 32'hDEADBEEF);
        tick();
        check("store_we_once", 32'(we_cnt - we0), 32'd1);

        // ---------------- load (independent rdata) ----------------
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; m_rdata = 32'h12345678;
        tick();
        d_req = 1'b0;
        tick(); tick(); tick();
        check("load_dack",   32'(d_ack), 32'd1);
        check("load_drdata", d_rdata,    32'h12345678);
        check("load_irdata_hold", i_rdata, 32'h8C010004);
        tick();

        // ---------------- simultaneous requests ----------------
        i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        m_rdata = 32'h0000AAAA;
        stall_ok = 1'b1;
        tick();                                   // Q1: data granted
        d_req = 1'b0;
        check("both_data_first", m_addr, 32'h30);
        stall_ok = stall_ok & stall_if;
        tick(); stall_ok = stall_ok & stall_if;
        tick(); stall_ok = stall_ok & stall_if;
        tick();                                   // Q4
        stall_ok = stall_ok & stall_if;
        check("both_dack", 32'(d_ack), 32'd1);
        tick();                                   // Q5: mandatory idle cycle
        stall_ok = stall_ok & stall_if;
        check("both_idle_gap", 32'(busy), 32'd0);
        tick();                                   // Q6: fetch granted
        stall_ok = stall_ok & stall_if;
        check("both_fetch_next", m_addr, 32'h44);
        tick(); stall_ok = stall_ok & stall_if;
        tick(); stall_ok = stall_ok & stall_if;
        tick();                                   // Q9
        check("both_iack", 32'(i_ack), 32'd1);
        check("both_stall_held", 32'(stall_ok), 32'd1);
        check("both_irdata", i_rdata, 32'h0000AAAA);
        i_req = 1'b0;
        tick();

        // ---------------- starvation ----------------
        ia0 = iack_cnt; da0 = dack_cnt;
        i_req = 1'b1; i_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
        n_ev = 0; ev = 5'b0;
        for (int k = 0; k < 40 && n_ev < 5; k++) begin
            tick();
            if (d_ack) begin
                ev[n_ev] = 1'b1; n_ev++;
            end else if (i_ack) begin
                ev[n_ev] = 1'b0; n_ev++;
            end
        end
        check("starve_events", 32'(n_ev), 32'd5);
`ifdef ARB_STARVE_GUARD_EN
        check("starve_order", 32'(ev), 32'b10111);     // D,D,D,I,D
        check("starve_iack_cnt", 32'(iack_cnt - ia0), 32'd1);
`else
        check("starve_order", 32'(ev), 32'b11111);     // data only
        check("starve_iack_cnt", 32'(iack_cnt - ia0), 32'd0);
`endif
        i_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("starve_drain", 32'(busy), 32'd0);

        // ---------------- reset during store ----------------
        we0 = we_cnt; da0 = dack_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h50; d_wdata = 32'hCAFEF00D;
        tick();                                   // sampling edge
        d_req = 1'b0; d_we = 1'b0;
        tick();                                   // second ACCESS cycle
        clrn = 1'b0;
        #1;
        check("rstmid_m_en", 32'(m_en), 32'd0);
        check("rstmid_m_we", 32'(m_we), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_m_addr", m_addr,  32'd0);
        tick(); tick();
        clrn = 1'b1;
        tick(); tick(); tick(); tick();
        check("rstmid_no_dack", 32'(dack_cnt - da0), 32'd0);
        check("rstmid_no_we",   32'(we_cnt - we0),   32'd0);
        i_req = 1'b1; i_addr = 32'h60; m_rdata = 32'hA5A5A5A5;
        tick();
        i_req = 1'b0;
        tick(); tick(); tick();
        check("rstmid_resume_ack",   32'(i_ack), 32'd1);
        check("rstmid_resume_rdata", i_rdata,    32'hA5A5A5A5);
        tick();

        // ---------------- zero wait states ----------------
        z_i_req = 1'b1; z_i_addr = 32'h70; z_m_rdata = 32'h0BADF00D;
        tick();                                   // sampling edge
        z_i_req = 1'b0;
        check("w0_access", 32'({z_m_en, z_i_ack}), 32'b10);
        tick();                                   // ack high before edge 2 after sample
        check("w0_iack",  32'(z_i_ack), 32'd1);
        check("w0_rdata", z_i_rdata,    32'h0BADF00D);
        tick();
        z_d_req = 1'b1; z_d_we = 1'b1; z_d_addr = 32'h74; z_d_wdata = 32'h11223344;
        tick();
        z_d_req = 1'b0; z_d_we = 1'b0;
        check("w0_store_we", 32'({z_m_we, z_m_en}), 32'b11);
        tick();
        check("w0_store_dack", 32'({z_d_ack, z_m_we}), 32'b10);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
